// File: rtl/ray_scan_scheduler.sv
// ray_scan_scheduler
//   Frame sequencer for the ray-marching datapath. Walks the screen in raster
//   order, issuing one fixed-point (x, y) coordinate per accepted handshake,
//   limits outstanding pixels with a credit counter and freezes the
//   configuration words at every frame start.
//
// Ports
//   out_stream_aclk  sole clock
//   periph_reset     synchronous active-high reset
//   enable           run frames back to back while high (sampled in IDLE/DONE)
//   cfg_in           live configuration words, word 0 in [31:0]
//   cfg_snapshot     configuration frozen for the current frame
//   issue_valid/issue_ready/issue_x/issue_y/issue_sof/issue_eol
//                    coordinate handshake into the ray unit
//   retire           one pixel consumed downstream, returns a credit
//   inflight         outstanding pixel count
//   busy             sequencer not idle
//   frame_done       one-cycle pulse per completed frame
//   frame_count      completed frames, wraps
//   err_underflow    sticky: retire seen with nothing in flight
module ray_scan_scheduler #(
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter logic [31:0] COORD_STEP   = 32'h0020_0000,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned CFG_WORDS    = 8,
    localparam int unsigned InflightW   = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                      out_stream_aclk,
    input  logic                      periph_reset,
    input  logic                      enable,
    input  logic [32*CFG_WORDS-1:0]   cfg_in,
    output logic [32*CFG_WORDS-1:0]   cfg_snapshot,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [31:0]               issue_x,
    output logic [31:0]               issue_y,
    output logic                      issue_sof,
    output logic                      issue_eol,
    input  logic                      retire,
    output logic [InflightW-1:0]      inflight,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               frame_count,
    output logic                      err_underflow
);

    localparam int unsigned ColW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned RowW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [ColW-1:0]      ColLast   = ColW'(H_RES - 1);
    localparam logic [RowW-1:0]      RowLast   = RowW'(V_RES - 1);
    localparam logic [InflightW-1:0] MaxCredit = InflightW'(MAX_INFLIGHT);

    typedef enum logic [2:0] {StIdle, StLoad, StIssue, StDrain, StDone} state_e;

    state_e                    state_q, state_d;
    logic [ColW-1:0]           col_q, col_d;
    logic [RowW-1:0]           row_q, row_d;
    logic [31:0]               x_q, x_d;
    logic [31:0]               y_q, y_d;
    logic [InflightW-1:0]      inflight_q, inflight_d;
    logic [32*CFG_WORDS-1:0]   cfg_q, cfg_d;
    logic [15:0]               count_q, count_d;
    logic                      err_q, err_d;

    logic fire;
    logic col_last;
    logic row_last;
    logic retire_ok;

    // Handshake and flag decode, all combinational from registered state.
    always_comb begin
        issue_valid = (state_q == StIssue) && (inflight_q < MaxCredit);
        fire        = issue_valid && issue_ready;
        col_last    = (col_q == ColLast);
        row_last    = (row_q == RowLast);
        // A retire with nothing outstanding is dropped, only flagged.
        retire_ok   = retire && (inflight_q != '0);
        issue_sof   = (state_q == StIssue) && (col_q == '0) && (row_q == '0);
        issue_eol   = (state_q == StIssue) && col_last;
        busy        = (state_q != StIdle);
        frame_done  = (state_q == StDone);
    end

    // Sequencer next state and raster walk.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        cfg_d   = cfg_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StLoad;
            end
            StLoad: begin
                cfg_d   = cfg_in;
                col_d   = '0;
                row_d   = '0;
                x_d     = '0;
                y_d     = '0;
                state_d = StIssue;
            end
            StIssue: begin
                if (fire) begin
                    if (!col_last) begin
                        col_d = col_q + 1'b1;
                        x_d   = x_q + COORD_STEP;
                    end else begin
                        col_d = '0;
                        x_d   = '0;
                        if (row_last) begin
                            row_d   = '0;
                            y_d     = '0;
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + 1'b1;
                            y_d   = y_q + COORD_STEP;
                        end
                    end
                end
            end
            StDrain: begin
                if ((inflight_q == '0) && !retire) state_d = StDone;
            end
            StDone: begin
                count_d = count_q + 16'd1;
                state_d = enable ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Credit counter: a simultaneous fire and retire cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (fire && !retire_ok) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!fire && retire_ok) begin
            inflight_d = inflight_q - 1'b1;
        end
        err_d = err_q | (retire && (inflight_q == '0));
    end

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            inflight_q <= '0;
            cfg_q      <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            x_q        <= x_d;
            y_q        <= y_d;
            inflight_q <= inflight_d;
            cfg_q      <= cfg_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    assign cfg_snapshot  = cfg_q;
    assign issue_x       = x_q;
    assign issue_y       = y_q;
    assign inflight      = inflight_q;
    assign frame_count   = count_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_ray_scan_scheduler.sv
// Bench for ray_scan_scheduler on a 4x3 screen with two credits. A pixel-index
// model predicts every output each cycle; directed scenarios add literal
// expectations on top.
module tb_ray_scan_scheduler;

    localparam int unsigned H    = 4;
    localparam int unsigned V    = 3;
    localparam int unsigned MAXI = 2;
    localparam int unsigned CW   = 8;
    localparam logic [31:0] STEP = 32'h0020_0000;
    localparam int unsigned IW   = $clog2(MAXI + 1);

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_ISSUE = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_DONE  = 4;

    logic              out_stream_aclk = 1'b0;
    logic              periph_reset    = 1'b1;
    logic              enable          = 1'b0;
    logic [32*CW-1:0]  cfg_in          = '0;
    logic [32*CW-1:0]  cfg_snapshot;
    logic              issue_valid;
    logic              issue_ready     = 1'b1;
    logic [31:0]       issue_x;
    logic [31:0]       issue_y;
    logic              issue_sof;
    logic              issue_eol;
    logic              retire          = 1'b0;
    logic [IW-1:0]     inflight;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_count;
    logic              err_underflow;

    ray_scan_scheduler #(
        .H_RES       (H),
        .V_RES       (V),
        .COORD_STEP  (STEP),
        .MAX_INFLIGHT(MAXI),
        .CFG_WORDS   (CW)
    ) dut (
        .out_stream_aclk(out_stream_aclk),
        .periph_reset   (periph_reset),
        .enable         (enable),
        .cfg_in         (cfg_in),
        .cfg_snapshot   (cfg_snapshot),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_x        (issue_x),
        .issue_y        (issue_y),
        .issue_sof      (issue_sof),
        .issue_eol      (issue_eol),
        .retire         (retire),
        .inflight       (inflight),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .err_underflow  (err_underflow)
    );

    always #5 out_stream_aclk = ~out_stream_aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Behavioural model: pixel index within the frame plus credit count.
    int              m_phase    = PH_IDLE;
    int              m_pix      = 0;
    int              m_inflight = 0;
    int              m_frames   = 0;
    bit              m_err      = 1'b0;
    logic [255:0]    m_cfg      = '0;
    bit              started    = 1'b0;

    // Fire log for the directed scenarios.
    int              fires    = 0;
    int              done_cnt = 0;
    logic [31:0]     fx [0:63];
    logic [31:0]     fy [0:63];
    bit   [63:0]     sof_mask = '0;
    bit   [63:0]     eol_mask = '0;

    bit auto_retire = 1'b1;
    bit rand_mode   = 1'b0;

    always @(negedge out_stream_aclk) begin
        bit          e_valid;
        bit          fire;
        bit          ret_ok;
        logic [31:0] e_x;
        logic [31:0] e_y;
        fire = 1'b0;
        if (started) begin
            e_valid = (m_phase == PH_ISSUE) && (m_inflight < MAXI);
            e_x = (m_phase == PH_ISSUE) ? (m_pix % H) * STEP : 32'd0;
            e_y = (m_phase == PH_ISSUE) ? (m_pix / H) * STEP : 32'd0;
            check("issue_valid", issue_valid, e_valid);
            check("issue_x", issue_x, e_x);
            check("issue_y", issue_y, e_y);
            check("issue_sof", issue_sof, (m_phase == PH_ISSUE) && (m_pix == 0));
            check("issue_eol", issue_eol, (m_phase == PH_ISSUE) && (m_pix % H == H - 1));
            check("inflight", inflight, m_inflight);
            check("busy", busy, m_phase != PH_IDLE);
            check("frame_done", frame_done, m_phase == PH_DONE);
            check("frame_count", frame_count, m_frames[15:0]);
            check("err_underflow", err_underflow, m_err);
            check("cfg_snapshot", cfg_snapshot, m_cfg);
            fire = e_valid && issue_ready;
            if (fire) begin
                if (fires < 64) begin
                    fx[fires] = issue_x;
                    fy[fires] = issue_y;
                    sof_mask[fires] = issue_sof;
                    eol_mask[fires] = issue_eol;
                end
                fires++;
            end
            if (frame_done) done_cnt++;
        end
        // Advance to the state after the coming rising edge.
        if (periph_reset) begin
            m_phase = PH_IDLE;
            m_pix = 0;
            m_inflight = 0;
            m_frames = 0;
            m_err = 1'b0;
            m_cfg = '0;
            started = 1'b1;
        end else if (started) begin
            ret_ok = retire && (m_inflight > 0);
            if (retire && m_inflight == 0) m_err = 1'b1;
            case (m_phase)
                PH_IDLE: if (enable) m_phase = PH_LOAD;
                PH_LOAD: begin
                    m_cfg = cfg_in;
                    m_pix = 0;
                    m_phase = PH_ISSUE;
                end
                PH_ISSUE: if (fire) begin
                    m_pix++;
                    if (m_pix == H * V) begin
                        m_pix = 0;
                        m_phase = PH_DRAIN;
                    end
                end
                PH_DRAIN: if (m_inflight == 0 && !retire) m_phase = PH_DONE;
                default: begin
                    m_frames++;
                    m_phase = enable ? PH_LOAD : PH_IDLE;
                end
            endcase
            m_inflight = m_inflight + (fire ? 1 : 0) - (ret_ok ? 1 : 0);
        end
    end

    // Background driver for retire / random backpressure.
    initial begin
        forever begin
            @(posedge out_stream_aclk);
            #1;
            if (rand_mode) begin
                issue_ready = ($urandom_range(3) != 0);
                retire      = ($urandom_range(2) == 0);
            end else if (auto_retire) begin
                retire = (m_inflight > 0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge out_stream_aclk);
            #1;
        end
    endtask

    task automatic wait_fires(input int n);
        for (int k = 0; k < 300; k++) begin
            @(posedge out_stream_aclk);
            #1;
            if (fires >= n) break;
        end
        if (fires < n) timeout("wait_fires");
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400; k++) begin
            @(posedge out_stream_aclk);
            #1;
            if (!busy) break;
        end
        if (busy) timeout("wait_idle");
    endtask

    task automatic clear_log();
        fires = 0;
        done_cnt = 0;
        sof_mask = '0;
        eol_mask = '0;
    endtask

    function automatic logic [255:0] rand_cfg();
        logic [255:0] v;
        for (int i = 0; i < CW; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    logic [255:0] cfg_a;
    logic [255:0] cfg_b;
    int           dsave;

    initial begin
        cycles(3);
        periph_reset = 1'b0;
        cycles(1);
        check("rst busy", busy, 1'b0);
        check("rst inflight", inflight, '0);
        check("rst frame_count", frame_count, 16'd0);
        check("rst cfg_snapshot", cfg_snapshot, '0);
        check("rst issue_valid", issue_valid, 1'b0);

        // Full frame, enable dropped after fire 5.
        clear_log();
        auto_retire = 1'b1;
        issue_ready = 1'b1;
        enable = 1'b1;
        wait_fires(5);
        enable = 1'b0;
        wait_idle();
        cycles(2);
        check("frame fires", fires, 12);
        check("fire1 x", fx[0], 32'h0);
        check("fire2 x", fx[1], 32'h0020_0000);
        check("fire3 x", fx[2], 32'h0040_0000);
        check("fire4 x", fx[3], 32'h0060_0000);
        check("fire5 x", fx[4], 32'h0);
        check("fire5 y", fy[4], 32'h0020_0000);
        check("fire12 x", fx[11], 32'h0060_0000);
        check("fire12 y", fy[11], 32'h0040_0000);
        check("sof fires", sof_mask[11:0], 12'b0000_0000_0001);
        check("eol fires", eol_mask[11:0], 12'b1000_1000_1000);
        check("done pulses", done_cnt, 1);
        check("frame_count 1", frame_count, 16'd1);
        check("idle busy", busy, 1'b0);

        // Credit stall with no retires.
        clear_log();
        auto_retire = 1'b0;
        retire = 1'b0;
        enable = 1'b1;
        wait_fires(2);
        enable = 1'b0;
        cycles(4);
        check("stall fires", fires, 2);
        check("stall valid", issue_valid, 1'b0);
        check("stall inflight", inflight, 2'd2);
        retire = 1'b1;
        cycles(1);
        retire = 1'b0;
        cycles(3);
        check("stall refire", fires, 3);
        check("stall inflight2", inflight, 2'd2);
        auto_retire = 1'b1;
        wait_idle();

        // Backpressure on pixel (2,1).
        clear_log();
        enable = 1'b1;
        wait_fires(6);
        issue_ready = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            check("bp x", issue_x, 32'h0040_0000);
            check("bp y", issue_y, 32'h0020_0000);
            check("bp valid", issue_valid, 1'b1);
            check("bp fires", fires, 6);
        end
        issue_ready = 1'b1;
        cycles(1);
        check("bp accept", fires, 7);
        wait_idle();

        // Configuration snapshot.
        clear_log();
        cfg_a = rand_cfg();
        cfg_b = ~cfg_a;
        cfg_in = cfg_a;
        enable = 1'b1;
        wait_fires(3);
        check("snap a", cfg_snapshot, cfg_a);
        cfg_in = cfg_b;
        cycles(3);
        check("snap held", cfg_snapshot, cfg_a);
        wait_fires(13);
        enable = 1'b0;
        check("snap b", cfg_snapshot, cfg_b);
        wait_idle();

        // Reset after fire 7.
        clear_log();
        enable = 1'b1;
        wait_fires(7);
        dsave = done_cnt;
        periph_reset = 1'b1;
        enable = 1'b0;
        cycles(1);
        periph_reset = 1'b0;
        check("rmid valid", issue_valid, 1'b0);
        check("rmid x", issue_x, 32'h0);
        check("rmid y", issue_y, 32'h0);
        check("rmid sof", issue_sof, 1'b0);
        check("rmid eol", issue_eol, 1'b0);
        check("rmid inflight", inflight, '0);
        check("rmid busy", busy, 1'b0);
        check("rmid frame_done", frame_done, 1'b0);
        check("rmid frame_count", frame_count, 16'd0);
        check("rmid cfg", cfg_snapshot, '0);
        cycles(3);
        check("rmid no done", done_cnt, dsave);

        // Underflow while idle.
        auto_retire = 1'b0;
        retire = 1'b1;
        cycles(1);
        retire = 1'b0;
        check("uf inflight", inflight, '0);
        check("uf flag", err_underflow, 1'b1);
        cycles(5);
        check("uf sticky", err_underflow, 1'b1);

        // Randomized traffic.
        rand_mode = 1'b1;
        for (int r = 0; r < 20; r++) begin
            enable = ($urandom_range(3) != 0);
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(7) == 0) cfg_in = rand_cfg();
                cycles(1);
            end
        end
        rand_mode = 1'b0;
        enable = 1'b0;
        retire = 1'b0;
        issue_ready = 1'b1;
        periph_reset = 1'b1;
        cycles(1);
        periph_reset = 1'b0;
        check("uf cleared", err_underflow, 1'b0);
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
